counter_mod_n_ctrl: RTL and testbench



---
 rtl/counter_mod_n_ctrl_pkg.sv | 13 +
 rtl/counter_mod_n_ctrl_if.sv | 27 ++
 rtl/counter_mod_n_ctrl_next_value.sv | 31 +++
 rtl/counter_mod_n_ctrl.sv | 74 +++++++
 tb/tb_counter_mod_n_ctrl.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/counter_mod_n_ctrl_pkg.sv
// Shared state encoding and direction constants for the mod-N counter slice.
package counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

endpackage

// File: rtl/counter_mod_n_ctrl_if.sv
// Control/status bundle between the microwave control FSM and one counter digit.
interface counter_mod_n_ctrl_if #(
  parameter int unsigned WIDTH = 3
);

  logic             en;
  logic             up;
  logic             recycle;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             busy;
  logic             done;

  modport master (
    output en, up, recycle, clear, load, load_value,
    input  count, tc, busy, done
  );

  modport slave (
    input  en, up, recycle, clear, load, load_value,
    output count, tc, busy, done
  );

endinterface

// File: rtl/counter_mod_n_ctrl_next_value.sv
// Combinational step for a 0..MAX_VALUE counter: terminal detect plus wrapped/held successor.
module counter_next_value
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH     = 3,
  parameter int unsigned MAX_VALUE = 7
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up,
  input  logic             recycle,
  output logic [WIDTH-1:0] next_count,
  output logic             at_terminal
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VALUE);

  always_comb begin
    at_terminal = (up == DIR_UP) ? (count == MAX_V) : (count == '0);
    next_count  = count;
    if (at_terminal) begin
      if (recycle) begin
        next_count = (up == DIR_UP) ? '0 : MAX_V;
      end
    end else if (up == DIR_UP) begin
      next_count = count + WIDTH'(1);
    end else begin
      next_count = count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/counter_mod_n_ctrl.sv
// Up/down mod-N counter digit with wrap/saturate modes, load/clear and IDLE/RUN/HOLD control.
module counter_mod_n_ctrl
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH     = 3,
  parameter int unsigned MAX_VALUE = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  counter_mod_n_ctrl_if.slave   bus
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VALUE);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] next_count;
  logic             at_terminal;

  counter_next_value #(
    .WIDTH     (WIDTH),
    .MAX_VALUE (MAX_VALUE)
  ) u_next (
    .count       (count_q),
    .up          (bus.up),
    .recycle     (bus.recycle),
    .next_count  (next_count),
    .at_terminal (at_terminal)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (bus.clear) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else if (bus.load) begin
      state_d = ST_IDLE;
      // compared at 32 bits so the clamp stays lint-quiet when MAX_VALUE is all-ones
      count_d = (32'(bus.load_value) > MAX_VALUE) ? MAX_V : bus.load_value;
    end else begin
      case (state_q)
        ST_IDLE, ST_RUN: begin
          if (bus.en) begin
            if (at_terminal && !bus.recycle) begin
              state_d = ST_HOLD;
            end else begin
              state_d = ST_RUN;
              count_d = next_count;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // reset gates tc so a down-counting enabled digit reports no carry while held in reset
  assign bus.tc    = reset & bus.en & at_terminal & (state_q != ST_HOLD);
  assign bus.count = count_q;
  assign bus.busy  = (state_q == ST_RUN);
  assign bus.done  = (state_q == ST_HOLD);

endmodule

// File: tb/tb_counter_mod_n_ctrl.sv
// Directed bench for counter_mod_n_ctrl: default 0..7 digit plus a cascaded 0..9 -> 0..5 pair.
module tb_counter_mod_n_ctrl;

  logic clk;
  logic reset;
  int unsigned checks;
  int unsigned errors;

  counter_mod_n_ctrl_if #(.WIDTH(3)) b0 ();
  counter_mod_n_ctrl_if #(.WIDTH(4)) b_lo ();
  counter_mod_n_ctrl_if #(.WIDTH(3)) b_hi ();

  counter_mod_n_ctrl #(.WIDTH(3), .MAX_VALUE(7)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b0)
  );

  counter_mod_n_ctrl #(.WIDTH(4), .MAX_VALUE(9)) u_lo (
    .clk   (clk),
    .reset (reset),
    .bus   (b_lo)
  );

  counter_mod_n_ctrl #(.WIDTH(3), .MAX_VALUE(5)) u_hi (
    .clk   (clk),
    .reset (reset),
    .bus   (b_hi)
  );

  assign b_hi.en = b_lo.tc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned tc_pulses;
    checks = 0;
    errors = 0;

    reset = 1'b0;
    b0.en = 1'b0; b0.up = 1'b1; b0.recycle = 1'b0;
    b0.clear = 1'b0; b0.load = 1'b0; b0.load_value = '0;
    b_lo.en = 1'b0; b_lo.up = 1'b1; b_lo.recycle = 1'b1;
    b_lo.clear = 1'b0; b_lo.load = 1'b0; b_lo.load_value = '0;
    b_hi.up = 1'b1; b_hi.recycle = 1'b1;
    b_hi.clear = 1'b0; b_hi.load = 1'b0; b_hi.load_value = '0;

    #2;
    check("rst_count", 32'(b0.count), 0);
    check("rst_busy", 32'(b0.busy), 0);
    check("rst_done", 32'(b0.done), 0);
    check("rst_tc", 32'(b0.tc), 0);
    #8;
    reset = 1'b1;

    // saturating count up: 1..7 then HOLD at 7
    b0.up = 1'b1; b0.recycle = 1'b0; b0.en = 1'b1;
    #1;
    for (int i = 1; i <= 10; i++) begin
      check($sformatf("sat_tc_%0d", i), 32'(b0.tc), (i == 8) ? 1 : 0);
      tick();
      check($sformatf("sat_cnt_%0d", i), 32'(b0.count), (i < 7) ? i : 7);
      check($sformatf("sat_busy_%0d", i), 32'(b0.busy), (i <= 7) ? 1 : 0);
      check($sformatf("sat_done_%0d", i), 32'(b0.done), (i >= 8) ? 1 : 0);
    end

    b0.en = 1'b0; b0.clear = 1'b1;
    tick();
    b0.clear = 1'b0;
    check("clr_count", 32'(b0.count), 0);
    check("clr_done", 32'(b0.done), 0);

    // wrapping count up, 17 edges
    b0.recycle = 1'b1; b0.en = 1'b1;
    tc_pulses = 0;
    #1;
    for (int i = 1; i <= 17; i++) begin
      if (b0.tc) tc_pulses++;
      tick();
      check($sformatf("wrap_cnt_%0d", i), 32'(b0.count), i % 8);
    end
    check("wrap_tc_pulses", tc_pulses, 2);
    check("wrap_busy", 32'(b0.busy), 1);

    // load 5 then saturating count down to 0
    b0.en = 1'b0; b0.load = 1'b1; b0.load_value = 3'd5;
    tick();
    b0.load = 1'b0;
    check("ld5_count", 32'(b0.count), 5);
    check("ld5_busy", 32'(b0.busy), 0);
    b0.up = 1'b0; b0.recycle = 1'b0; b0.en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("dn_cnt_%0d", i), 32'(b0.count), 5 - i);
    end
    check("dn_tc_at0", 32'(b0.tc), 1);
    tick();
    check("dn_hold_count", 32'(b0.count), 0);
    check("dn_hold_done", 32'(b0.done), 1);
    check("dn_hold_busy", 32'(b0.busy), 0);
    b0.up = 1'b1; b0.recycle = 1'b1;
    #1;
    check("hold_tc", 32'(b0.tc), 0);
    tick();
    check("hold_frozen", 32'(b0.count), 0);
    check("hold_still_done", 32'(b0.done), 1);
    b0.clear = 1'b1;
    tick();
    b0.clear = 1'b0;
    check("hold_clr_done", 32'(b0.done), 0);
    check("hold_clr_busy", 32'(b0.busy), 0);

    // asynchronous reset mid-count
    b0.up = 1'b1; b0.recycle = 1'b1; b0.en = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("pre_arst_count", 32'(b0.count), 4);
    check("pre_arst_busy", 32'(b0.busy), 1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_count", 32'(b0.count), 0);
    check("arst_busy", 32'(b0.busy), 0);
    b0.up = 1'b0;
    #1;
    check("arst_tc_down", 32'(b0.tc), 0);
    b0.up = 1'b1;
    reset = 1'b1;
    tick();
    check("post_arst_count", 32'(b0.count), 1);

    // priority: clear > load > step
    b0.en = 1'b0; b0.load = 1'b1; b0.load_value = 3'd3;
    tick();
    check("ld3_count", 32'(b0.count), 3);
    b0.clear = 1'b1; b0.load = 1'b1; b0.load_value = 3'd6; b0.en = 1'b1;
    tick();
    check("clr_ld_count", 32'(b0.count), 0);
    check("clr_ld_busy", 32'(b0.busy), 0);
    b0.clear = 1'b0; b0.load_value = 3'd2;
    tick();
    b0.load = 1'b0; b0.en = 1'b0;
    check("ld_en_count", 32'(b0.count), 2);
    check("ld_en_busy", 32'(b0.busy), 0);
    check("ld_en_done", 32'(b0.done), 0);

    // clamp on load and cascaded 0..9 -> 0..5 chain
    b_lo.load = 1'b1; b_lo.load_value = 4'd15;
    tick();
    b_lo.load = 1'b0;
    check("lo_clamp", 32'(b_lo.count), 9);
    check("hi_init", 32'(b_hi.count), 0);
    b_lo.up = 1'b1; b_lo.recycle = 1'b1; b_lo.en = 1'b1;
    #1;
    check("lo_tc_at9", 32'(b_lo.tc), 1);
    tick();
    check("lo_wrap", 32'(b_lo.count), 0);
    check("hi_step1", 32'(b_hi.count), 1);
    tc_pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      if (b_lo.tc) tc_pulses++;
      tick();
    end
    check("lo_after20", 32'(b_lo.count), 0);
    check("lo_tc_pulses", tc_pulses, 2);
    check("hi_after20", 32'(b_hi.count), 3);
    b_lo.en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
